// File: rtl/uart_lowpower_tx_fifo.sv
// uart_lowpower_tx_fifo: FIFO-buffered UART transmitter with configurable framing and idle-timeout sleep
// Ports: clk/rst (sync, active-high); tx_start/data_in push a word when ready=1;
// parity_mode (0 none, 1 even, 2 odd, 3 none) and stop2 are stored with each word;
// tx serial line (idle high); busy = frame in flight or FIFO non-empty; ready = FIFO not full;
// overflow pulses the cycle after a rejected push; sleep marks the gated SLEEP state;
// state exposes the FSM encoding.
module uart_lowpower_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 busy,
  output logic                 ready,
  output logic                 overflow,
  output logic                 sleep,
  output logic [2:0]           state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int EW = DATA_BITS + 3;
  typedef enum logic [2:0] {SLEEP = 3'd0, IDLE = 3'd1, START = 3'd2, DATA = 3'd3, PARITY = 3'd4, STOP = 3'd5} state_t;
  state_t st, nx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic [CW-1:0] baud;
  logic [IW-1:0] bit_idx;
  logic [TW-1:0] idle_cnt;
  logic [DATA_BITS-1:0] sh;
  logic par_en, par_bit, stop_l, stop_half;
  logic empty, full, push, pop, baud_end, last_bit, stop_end;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign push = tx_start & ~full;
  assign head = mem[rd];
  assign baud_end = baud == CW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_idx == IW'(DATA_BITS - 1);
  // second stop bit reuses the baud counter with a half flag
  assign stop_end = baud_end & (~stop_l | stop_half);
  // a word leaves the FIFO exactly when a new frame is entered
  assign pop = nx == START && st != START;
  assign tx = st == START ? 1'b0 : st == DATA ? sh[0] : st == PARITY ? par_bit : 1'b1;
  assign busy = (st != IDLE && st != SLEEP) || !empty;
  assign ready = ~full;
  assign sleep = st == SLEEP;
  assign state = st;
  always_comb begin
    nx = IDLE;
    case (st)
      SLEEP:   nx = empty ? SLEEP : IDLE;
      IDLE:    nx = !empty ? START : (idle_cnt == TW'(IDLE_TIMEOUT - 1) && !push) ? SLEEP : IDLE;
      START:   nx = baud_end ? DATA : START;
      DATA:    nx = !(baud_end && last_bit) ? DATA : par_en ? PARITY : STOP;
      PARITY:  nx = baud_end ? STOP : PARITY;
      STOP:    nx = !stop_end ? STOP : empty ? IDLE : START;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr] <= {stop2, parity_mode, data_in};
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      baud <= '0;
      bit_idx <= '0;
      idle_cnt <= '0;
      sh <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      stop_l <= 1'b0;
      stop_half <= 1'b0;
      overflow <= 1'b0;
    end else begin
      st <= nx;
      baud <= (nx != st || baud_end || st == SLEEP || st == IDLE) ? '0 : baud + 1'b1;
      bit_idx <= (st == DATA && nx == DATA) ? bit_idx + IW'(baud_end) : '0;
      stop_half <= (st == STOP && nx == STOP) ? stop_half ^ baud_end : 1'b0;
      idle_cnt <= st == SLEEP ? idle_cnt : (st == IDLE && nx == IDLE && empty && !push) ? idle_cnt + 1'b1 : '0;
      overflow <= tx_start & full;
      wr <= push ? wr + 1'b1 : wr;
      rd <= pop ? rd + 1'b1 : rd;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        sh <= head[DATA_BITS-1:0];
        // modes 1 and 2 are the only ones whose two bits differ
        par_en <= ^head[EW-2 -: 2];
        par_bit <= (^head[DATA_BITS-1:0]) ^ (head[EW-2 -: 2] == 2'd2);
        stop_l <= head[EW-1];
      end else if (st == DATA && baud_end) begin
        sh <= sh >> 1;
      end
    end
  end
endmodule
